// File: rtl/cpu6_pkg.sv
// Shared definitions for the 6-bit CPU: widths, opcodes and fetch states.
package cpu6_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 10;
  localparam int OP_W    = 4;
  localparam int OPR_W   = INSTR_W - OP_W;

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1011;
  localparam logic [OP_W-1:0] OP_BRC = 4'b1100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BRWAIT = 2'd2,
    HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_hazard_tracker.sv
// Tracks how many slots have issued since the last accumulator writer and
// requests a stall when an accumulator reader would arrive too early.
module fetch_hazard_tracker
  import cpu6_pkg::*;
#(
  parameter int          P_HAZ_GAP = 1,
  parameter logic [15:0] P_WR_MASK = 16'h0140,
  parameter logic [15:0] P_RD_MASK = 16'h1040
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            slot,
  input  logic            issue_op,
  output logic            stall_req
);

  localparam logic [1:0] GAP = 2'(P_HAZ_GAP);

  logic [1:0] age;
  logic       wr_hit;
  logic       rd_hit;

  assign wr_hit    = P_WR_MASK[op];
  assign rd_hit    = P_RD_MASK[op];
  // Uses the age before this slot, so an opcode that both reads and writes
  // is checked against the previous writer.
  assign stall_req = rd_hit && (age < GAP);

  // Age resets on an issued writer and otherwise climbs to GAP on every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= GAP;
    end else if (slot) begin
      if (issue_op && wr_hit) begin
        age <= 2'd0;
      end else if (age < GAP) begin
        age <= age + 2'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one slot per cycle and
// inserts bubbles for accumulator hazards and unresolved conditional branches.
module fetch_seq_ctrl
  import cpu6_pkg::*;
#(
  parameter int          P_HAZ_GAP = 1,
  parameter logic [15:0] P_WR_MASK = 16'h0140,
  parameter logic [15:0] P_RD_MASK = 16'h1040
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  output logic [ADDR_W-1:0]  ROM_AD,
  input  logic [INSTR_W-1:0] ROM_Q,
  output logic [INSTR_W-1:0] INSTR,
  output logic               INSTR_VALID,
  input  logic               BR_VALID,
  input  logic               BR_TAKEN,
  output logic               HALTED,
  output logic [7:0]         BUBBLE_CNT
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [ADDR_W-1:0]  tgt;
  logic [ADDR_W-1:0]  tgt_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic               vld_nxt;
  logic               halted_nxt;
  logic               bubble;
  logic               slot;
  logic               issue_op;
  logic               stall_req;
  logic [OP_W-1:0]    op;
  logic [OPR_W-1:0]   opr;

  assign op     = ROM_Q[INSTR_W-1:OPR_W];
  assign opr    = ROM_Q[OPR_W-1:0];
  assign ROM_AD = pc;

  fetch_hazard_tracker #(
    .P_HAZ_GAP (P_HAZ_GAP),
    .P_WR_MASK (P_WR_MASK),
    .P_RD_MASK (P_RD_MASK)
  ) u_haz (
    .clk       (CLK),
    .rst       (RST),
    .op        (op),
    .slot      (slot),
    .issue_op  (issue_op),
    .stall_req (stall_req)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, next PC and the slot to issue.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    tgt_nxt    = tgt;
    instr_nxt  = INSTR;
    vld_nxt    = 1'b0;
    halted_nxt = HALTED;
    bubble     = 1'b0;
    slot       = 1'b0;
    issue_op   = 1'b0;
    case (state)
      IDLE: begin
        if (EN) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (EN) begin
          slot    = 1'b1;
          vld_nxt = 1'b1;
          if (stall_req) begin
            instr_nxt = {OP_NOP, {OPR_W{1'b0}}};
            bubble    = 1'b1;
          end else if (op == OP_JMP && opr == pc) begin
            instr_nxt  = {OP_NOP, {OPR_W{1'b0}}};
            halted_nxt = 1'b1;
            state_nxt  = HALT;
          end else if (op == OP_JMP) begin
            // Target is known in fetch, so the jump costs only this NOP slot.
            instr_nxt = {OP_NOP, {OPR_W{1'b0}}};
            pc_nxt    = opr;
          end else if (op == OP_BRC) begin
            instr_nxt = ROM_Q;
            issue_op  = 1'b1;
            tgt_nxt   = opr;
            pc_nxt    = pc + 6'd1;
            state_nxt = BRWAIT;
          end else begin
            instr_nxt = ROM_Q;
            issue_op  = 1'b1;
            pc_nxt    = pc + 6'd1;
          end
        end
      end
      BRWAIT: begin
        // Bubbles keep flowing regardless of EN until execute resolves.
        slot      = 1'b1;
        vld_nxt   = 1'b1;
        instr_nxt = {OP_NOP, {OPR_W{1'b0}}};
        bubble    = 1'b1;
        if (BR_VALID) begin
          if (BR_TAKEN) begin
            pc_nxt = tgt;
          end
          state_nxt = RUN;
        end
      end
      HALT: begin
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered PC, branch target and issue outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc          <= '0;
      tgt         <= '0;
      INSTR       <= '0;
      INSTR_VALID <= 1'b0;
      HALTED      <= 1'b0;
      BUBBLE_CNT  <= 8'd0;
    end else begin
      pc          <= pc_nxt;
      tgt         <= tgt_nxt;
      INSTR       <= instr_nxt;
      INSTR_VALID <= vld_nxt;
      HALTED      <= halted_nxt;
      if (bubble) begin
        BUBBLE_CNT <= sat_inc8(BUBBLE_CNT);
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Scoreboard bench for fetch_seq_ctrl: directed programs in a modelled ROM,
// expected issue stream queued up front and checked by a negedge monitor.
module tb_fetch_seq_ctrl;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [5:0] ROM_AD;
  logic [9:0] ROM_Q;
  logic [9:0] INSTR;
  logic       INSTR_VALID;
  logic       BR_VALID;
  logic       BR_TAKEN;
  logic       HALTED;
  logic [7:0] BUBBLE_CNT;

  logic [9:0] rom [64];
  logic [9:0] exp_q [$];
  logic [9:0] exp_v;
  int         n_cmp;
  int         n_fail;

  fetch_seq_ctrl #(
    .P_HAZ_GAP (1),
    .P_WR_MASK (16'h0140),
    .P_RD_MASK (16'h1040)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .ROM_AD      (ROM_AD),
    .ROM_Q       (ROM_Q),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .BR_VALID    (BR_VALID),
    .BR_TAKEN    (BR_TAKEN),
    .HALTED      (HALTED),
    .BUBBLE_CNT  (BUBBLE_CNT)
  );

  assign ROM_Q = rom[ROM_AD];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: every valid slot must match the next queued expectation.
  always @(negedge CLK) begin
    if (INSTR_VALID) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: INSTR=%h issued, nothing expected", INSTR);
      end else begin
        exp_v = exp_q.pop_front();
        if (INSTR !== exp_v) begin
          n_fail++;
          $display("FAIL issue_stream: INSTR=%h expected %h", INSTR, exp_v);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clr_rom();
    for (int i = 0; i < 64; i++) rom[i] = 10'd0;
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    EN       = 1'b0;
    BR_VALID = 1'b0;
    BR_TAKEN = 1'b0;
    tick(1);
    RST = 1'b0;
    exp_q.delete();
  endtask

  task automatic end_test(input string nm);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    RST = 1'b1; EN = 1'b0; BR_VALID = 1'b0; BR_TAKEN = 1'b0;
    clr_rom();

    // Reset values
    do_reset();
    chk("rst_rom_ad", ROM_AD, 0);
    chk("rst_instr", INSTR, 0);
    chk("rst_valid", INSTR_VALID, 0);
    chk("rst_halted", HALTED, 0);
    chk("rst_bubbles", BUBBLE_CNT, 0);

    // Writer then dependent reader: one hazard bubble, PC held at 1
    do_reset(); clr_rom();
    rom[0] = {4'b1000, 6'd60};
    rom[1] = {4'b0110, 6'd1};
    rom[2] = {4'b1011, 6'd2};
    exp_q.push_back(rom[0]); exp_q.push_back(10'd0);
    exp_q.push_back(rom[1]); exp_q.push_back(10'd0);
    EN = 1'b1;
    tick(2);
    chk("haz_pc_after_writer", ROM_AD, 1);
    tick(1);
    chk("haz_pc_held", ROM_AD, 1);
    chk("haz_bubble_cnt", BUBBLE_CNT, 1);
    tick(2);
    chk("haz_halted", HALTED, 1);
    tick(2);
    chk("haz_pc_final", ROM_AD, 2);
    chk("haz_bubble_final", BUBBLE_CNT, 1);
    end_test("haz");

    // Padded program: no bubble before 0110; 0110 itself writes, so the
    // branch reader right after it takes one bubble
    do_reset(); clr_rom();
    rom[0] = {4'b1000, 6'd7};
    rom[1] = 10'd0;
    rom[2] = {4'b0110, 6'd3};
    rom[3] = {4'b1100, 6'd5};
    rom[4] = {4'b1011, 6'd4};
    exp_q.push_back(rom[0]); exp_q.push_back(rom[1]); exp_q.push_back(rom[2]);
    exp_q.push_back(10'd0);  exp_q.push_back(rom[3]);
    exp_q.push_back(10'd0);  exp_q.push_back(10'd0);
    EN = 1'b1;
    tick(4);
    chk("pad_pc_after_0110", ROM_AD, 3);
    chk("pad_no_bubble", BUBBLE_CNT, 0);
    tick(1);
    chk("pad_brc_bubble", BUBBLE_CNT, 1);
    tick(1);
    chk("pad_pc_after_brc", ROM_AD, 4);
    BR_VALID = 1'b1; BR_TAKEN = 1'b0;
    tick(1);
    BR_VALID = 1'b0;
    chk("pad_pc_not_taken", ROM_AD, 4);
    tick(3);
    chk("pad_halted", HALTED, 1);
    chk("pad_bubble_final", BUBBLE_CNT, 2);
    end_test("pad");

    // Conditional branch, taken then not taken, resolved 3 cycles after issue
    for (int t = 1; t >= 0; t--) begin
      do_reset(); clr_rom();
      rom[0] = {4'b0001, 6'd10};
      rom[1] = {4'b0010, 6'd11};
      rom[2] = {4'b0011, 6'd12};
      rom[3] = {4'b1100, 6'd2};
      rom[4] = {4'b0100, 6'd13};
      exp_q.push_back(rom[0]); exp_q.push_back(rom[1]);
      exp_q.push_back(rom[2]); exp_q.push_back(rom[3]);
      exp_q.push_back(10'd0);  exp_q.push_back(10'd0); exp_q.push_back(10'd0);
      exp_q.push_back((t == 1) ? rom[2] : rom[4]);
      EN = 1'b1;
      tick(5);
      chk("br_pc_after_issue", ROM_AD, 4);
      tick(2);
      BR_VALID = 1'b1; BR_TAKEN = (t == 1);
      tick(1);
      BR_VALID = 1'b0; BR_TAKEN = 1'b0;
      chk("br_pc_resolved", ROM_AD, (t == 1) ? 2 : 4);
      chk("br_bubbles", BUBBLE_CNT, 3);
      tick(1);
      EN = 1'b0;
      tick(3);
      chk("br_pc_next_fetch", ROM_AD, (t == 1) ? 3 : 5);
      end_test("br");
    end

    // Self-jump halt at address 7
    do_reset(); clr_rom();
    rom[7] = {4'b1011, 6'd7};
    for (int i = 0; i < 8; i++) exp_q.push_back(10'd0);
    EN = 1'b1;
    tick(9);
    chk("halt_flag", HALTED, 1);
    chk("halt_nop_valid", INSTR_VALID, 1);
    tick(1);
    chk("halt_valid_low", INSTR_VALID, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("halt_pc_frozen", ROM_AD, 7);
    end
    chk("halt_bubbles", BUBBLE_CNT, 0);
    end_test("halt");

    // JMP to 62, PC wraps 63 -> 0, JMP NOPs not counted as bubbles
    do_reset(); clr_rom();
    rom[0]  = {4'b1011, 6'd62};
    rom[62] = {4'b0001, 6'd1};
    exp_q.push_back(10'd0); exp_q.push_back(rom[62]); exp_q.push_back(10'd0);
    EN = 1'b1;
    tick(2);
    chk("wrap_jmp_pc", ROM_AD, 62);
    tick(2);
    chk("wrap_pc_zero", ROM_AD, 0);
    EN = 1'b0;
    chk("wrap_bubbles", BUBBLE_CNT, 0);
    tick(2);
    end_test("wrap");

    // JMP at address 5 to 20
    do_reset(); clr_rom();
    rom[5] = {4'b1011, 6'd20};
    for (int i = 0; i < 6; i++) exp_q.push_back(10'd0);
    EN = 1'b1;
    tick(7);
    chk("jmp_pc", ROM_AD, 20);
    chk("jmp_bubbles", BUBBLE_CNT, 0);
    EN = 1'b0;
    tick(2);
    end_test("jmp");

    // Not-taken branch at address 63 continues at 0
    do_reset(); clr_rom();
    rom[0]  = {4'b1011, 6'd63};
    rom[63] = {4'b1100, 6'd9};
    exp_q.push_back(10'd0); exp_q.push_back(rom[63]); exp_q.push_back(10'd0);
    EN = 1'b1;
    tick(3);
    chk("br63_pc_wrapped", ROM_AD, 0);
    BR_VALID = 1'b1; BR_TAKEN = 1'b0;
    tick(1);
    BR_VALID = 1'b0; EN = 1'b0;
    chk("br63_pc_resolved", ROM_AD, 0);
    chk("br63_bubbles", BUBBLE_CNT, 1);
    tick(2);
    chk("br63_pc_held", ROM_AD, 0);
    end_test("br63");

    // Reset while waiting on a branch; the later outcome pulse is ignored
    do_reset(); clr_rom();
    rom[0] = {4'b1100, 6'd30};
    exp_q.push_back(rom[0]);
    EN = 1'b1;
    tick(3);
    RST = 1'b1;
    #1;
    chk("mid_rst_pc", ROM_AD, 0);
    chk("mid_rst_valid", INSTR_VALID, 0);
    chk("mid_rst_instr", INSTR, 0);
    chk("mid_rst_bubbles", BUBBLE_CNT, 0);
    chk("mid_rst_halted", HALTED, 0);
    EN = 1'b0;
    tick(1);
    RST = 1'b0;
    BR_VALID = 1'b1; BR_TAKEN = 1'b1;
    tick(1);
    BR_VALID = 1'b0; BR_TAKEN = 1'b0;
    tick(3);
    chk("post_rst_pc", ROM_AD, 0);
    chk("post_rst_valid", INSTR_VALID, 0);
    chk("post_rst_bubbles", BUBBLE_CNT, 0);
    end_test("mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
